// File: rtl/rr_enc_pkg.sv
// rtl/rr_enc_pkg.sv - shared sizing, state and code types for the round-robin encoder
package rr_enc_pkg;
  localparam int N = 4;
  localparam int W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  typedef logic [W-1:0] code_t;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority search over the request vector
module rr_pick
  import rr_enc_pkg::*;
(
  input  logic [N-1:0] req,
  input  code_t        start,
  output code_t        pick,
  output logic         any,
  output logic         multi
);

  logic [2:0] ones;
  logic       found;
  code_t      idx;

  always_comb begin
    pick  = start;
    found = 1'b0;
    idx   = start;
    // Walk from start upward with 2-bit wrap; the first hit wins.
    for (int k = 0; k < N; k++) begin
      idx = code_t'(start + k[W-1:0]);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ones = 3'd0;
    for (int i = 0; i < N; i++) begin
      ones = ones + {2'b00, req[i]};
    end
  end

  assign any   = |req;
  assign multi = (ones > 3'd1);

endmodule

// File: rtl/rr_encoder_4to2.sv
// rtl/rr_encoder_4to2.sv - registered round-robin 4-to-2 encoder with valid/ready output
module rr_encoder_4to2
  import rr_enc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output code_t        code,
  output logic         multi,
  output code_t        ptr
);

  state_t state;
  logic   accept;
  code_t  next_ptr;
  code_t  start;
  code_t  pick;
  logic   pick_any;
  logic   pick_multi;
  logic   capture_ok;

  assign accept     = (state == HOLD) && out_valid && out_ready;
  assign next_ptr   = code_t'(code + 2'd1);
  // On accept the search must already use the advanced pointer so back-to-back grants stay fair.
  assign start      = accept ? next_ptr : ptr;
  assign capture_ok = en && pick_any;

  rr_pick u_pick (
    .req   (req),
    .start (start),
    .pick  (pick),
    .any   (pick_any),
    .multi (pick_multi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      code      <= '0;
      multi     <= 1'b0;
      ptr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture_ok) begin
            code      <= pick;
            multi     <= pick_multi;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (accept) begin
            ptr <= next_ptr;
            if (capture_ok) begin
              code      <= pick;
              multi     <= pick_multi;
              out_valid <= 1'b1;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_encoder_4to2.sv
// tb/tb_rr_encoder_4to2.sv - directed and randomized checks of rr_encoder_4to2 against a reference model
module tb_rr_encoder_4to2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       out_ready;
  logic       out_valid;
  logic [1:0] code;
  logic       multi;
  logic [1:0] ptr;

  int checks;
  int failures;

  int         m_ptr;
  int         m_code;
  bit         m_valid;
  bit         m_multi;
  logic [3:0] m_req_cap;

  rr_encoder_4to2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .code      (code),
    .multi     (multi),
    .ptr       (ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_pick(input logic [3:0] r, input int from);
    for (int k = 0; k < 4; k++) begin
      if (r[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_code = 0; m_valid = 0; m_multi = 0; m_req_cap = 4'b0000;
  endtask

  task automatic model_capture(input logic [3:0] r);
    m_code    = ref_pick(r, m_ptr);
    m_multi   = ($countones(r) > 1);
    m_valid   = 1;
    m_req_cap = r;
  endtask

  task automatic model_clock(input logic e, input logic [3:0] r, input logic rdy);
    if (m_valid) begin
      if (rdy) begin
        m_ptr = (m_code + 1) % 4;
        if (e && r != 4'b0000) model_capture(r);
        else m_valid = 0;
      end
    end else if (e && r != 4'b0000) begin
      model_capture(r);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [3:0] dec;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
    if (m_valid) begin
      check({tag, ".code"}, 32'(code), 32'(m_code));
      check({tag, ".multi"}, 32'(multi), 32'(m_multi));
      // Decoder fed by code with en=out_valid must light exactly the granted request line.
      dec = out_valid ? (4'b0001 << code) : 4'b0000;
      check({tag, ".dec_onehot"}, 32'(dec & m_req_cap), 32'(dec));
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [3:0] r, input logic rdy);
    en = e; req = r; out_ready = rdy;
    model_clock(e, r, rdy);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0; req = 4'b0000; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  logic [1:0] fair_seq [8];

  initial begin
    checks = 0;
    failures = 0;
    fair_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};

    do_reset();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.code", 32'(code), 32'd0);
    check("reset.multi", 32'(multi), 32'd0);
    check("reset.ptr", 32'(ptr), 32'd0);

    step("cap0101", 1, 4'b0101, 0);
    check("cap0101.code_lit", 32'(code), 32'd0);
    check("cap0101.multi_lit", 32'(multi), 32'd1);
    for (int i = 0; i < 5; i++) step("hold_stable", 1, 4'b1000, 0);
    check("hold_stable.code_lit", 32'(code), 32'd0);

    step("b2b_1", 1, 4'b0101, 1);
    check("b2b_1.code_lit", 32'(code), 32'd2);
    check("b2b_1.ptr_lit", 32'(ptr), 32'd1);
    check("b2b_1.valid_lit", 32'(out_valid), 32'd1);
    step("b2b_2", 1, 4'b0101, 1);
    check("b2b_2.code_lit", 32'(code), 32'd0);
    check("b2b_2.ptr_lit", 32'(ptr), 32'd3);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      step("fair", 1, 4'b1111, 1);
      check($sformatf("fair[%0d].code_lit", i), 32'(code), 32'(fair_seq[i]));
      check($sformatf("fair[%0d].multi_lit", i), 32'(multi), 32'd1);
    end

    step("wrap_drain", 0, 4'b0000, 1);
    step("wrap_c2", 1, 4'b0100, 0);
    step("wrap_acc", 0, 4'b0000, 1);
    check("wrap.ptr3_lit", 32'(ptr), 32'd3);
    step("wrap_0110", 1, 4'b0110, 0);
    check("wrap_0110.code_lit", 32'(code), 32'd1);
    step("wrap_acc2", 0, 4'b0000, 1);
    step("wrap_c2b", 1, 4'b0100, 0);
    step("wrap_acc3", 0, 4'b0000, 1);
    step("wrap_1000", 1, 4'b1000, 0);
    check("wrap_1000.code_lit", 32'(code), 32'd3);
    step("wrap_acc4", 0, 4'b0000, 1);
    check("wrap_acc4.ptr_lit", 32'(ptr), 32'd0);
    check("wrap_acc4.valid_lit", 32'(out_valid), 32'd0);

    step("en0_idle", 0, 4'b1111, 0);
    check("en0_idle.valid_lit", 32'(out_valid), 32'd0);
    step("en0_cap", 1, 4'b0010, 0);
    step("en0_hold_acc", 0, 4'b1111, 1);
    check("en0_hold_acc.valid_lit", 32'(out_valid), 32'd0);

    step("rst_cap", 1, 4'b0001, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.out_valid", 32'(out_valid), 32'd0);
    check("async_rst.code", 32'(code), 32'd0);
    check("async_rst.multi", 32'(multi), 32'd0);
    check("async_rst.ptr", 32'(ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_req0", 1, 4'b0000, 1);
    step("post_rst_req0b", 1, 4'b0000, 0);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
